// File: rtl/lsu_resp_pkg.sv
// rtl/lsu_resp_pkg.sv - shared load/store types: load-type encoding and response queue entry
package lsu_resp_pkg;

    localparam int COMMIT_ID_WIDTH = 5;
    localparam int REG_ADDR_WIDTH  = 5;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4,
        LD_DL = 3'd5,
        LD_DH = 3'd6
    } ld_type_e;

    typedef struct packed {
        ld_type_e                   typ;
        logic [1:0]                 addr_lo;
        logic [COMMIT_ID_WIDTH-1:0] commit_id;
        logic [REG_ADDR_WIDTH-1:0]  reg_waddr;
        logic [31:0]                data;
        logic                       have;
    } lsu_resp_entry_t;

    // One-hot order {lb, lh, lw, lbu, lhu, ldl, ldh}; no flag set decodes as a word load.
    function automatic ld_type_e ld_encode(input logic [6:0] oh);
        ld_type_e t;
        if (oh[4])      t = LD_W;
        else if (oh[6]) t = LD_B;
        else if (oh[3]) t = LD_BU;
        else if (oh[5]) t = LD_H;
        else if (oh[2]) t = LD_HU;
        else if (oh[1]) t = LD_DL;
        else if (oh[0]) t = LD_DH;
        else            t = LD_W;
        return t;
    endfunction

endpackage

// File: rtl/lsu_resp_load_extend.sv
// rtl/lsu_resp_load_extend.sv - byte/half select with sign or zero extension of a read word
module load_extend
    import lsu_resp_pkg::*;
(
    input  ld_type_e    typ_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{addr_lo_i, 3'b000} +: 8];
        half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (typ_i)
            LD_B:    data_o = {{24{byte_v[7]}}, byte_v};
            LD_BU:   data_o = {24'h0, byte_v};
            LD_H:    data_o = {{16{half_v[15]}}, half_v};
            LD_HU:   data_o = {16'h0, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_resp.sv
// rtl/lsu_resp.sv - in-order load response queue with extension, ldl/ldh merge and registered writeback
module lsu_resp
    import lsu_resp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_fire_i,
    input  logic                       req_op_load_i,
    input  logic                       req_op_lb_i,
    input  logic                       req_op_lh_i,
    input  logic                       req_op_lw_i,
    input  logic                       req_op_lbu_i,
    input  logic                       req_op_lhu_i,
    input  logic                       req_op_ldl_i,
    input  logic                       req_op_ldh_i,
    input  logic [1:0]                 req_addr_lo_i,
    input  logic [COMMIT_ID_WIDTH-1:0] req_commit_id_i,
    input  logic [REG_ADDR_WIDTH-1:0]  req_reg_waddr_i,
    input  logic                       rsp_valid_i,
    input  logic [31:0]                rsp_rdata_i,
    output logic                       full_o,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [63:0]                wb_data_o,
    output logic                       wb_is64_o,
    output logic [COMMIT_ID_WIDTH-1:0] wb_commit_id_o,
    output logic [REG_ADDR_WIDTH-1:0]  wb_reg_waddr_o,
    output logic                       rsp_orphan_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    lsu_resp_entry_t            entry_q [DEPTH];
    lsu_resp_entry_t            entry_d [DEPTH];
    logic [PTR_W-1:0]           head_q, head_d, fill_q, fill_d, tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       wb_valid_q, wb_valid_d;
    logic [63:0]                wb_data_q, wb_data_d;
    logic                       wb_is64_q, wb_is64_d;
    logic [COMMIT_ID_WIDTH-1:0] wb_commit_id_q, wb_commit_id_d;
    logic [REG_ADDR_WIDTH-1:0]  wb_reg_waddr_q, wb_reg_waddr_d;
    logic                       orphan_q, orphan_d;

    logic [PTR_W-1:0] head1;
    logic             push, unfilled, fill_en, slot_free;
    logic             avail_head, avail_head1, head_is_dl;
    logic             pop_single, pop_pair;
    logic [1:0]       pop_n;
    logic [31:0]      word_head, word_head1, ext_mem, ext_byp;

    load_extend u_ext_mem (
        .typ_i     (entry_q[head_q].typ),
        .addr_lo_i (entry_q[head_q].addr_lo),
        .word_i    (entry_q[head_q].data),
        .data_o    (ext_mem)
    );

    load_extend u_ext_byp (
        .typ_i     (entry_q[head_q].typ),
        .addr_lo_i (entry_q[head_q].addr_lo),
        .word_i    (rsp_rdata_i),
        .data_o    (ext_byp)
    );

    always_comb begin
        head1     = head_q + PTR_W'(1);
        push      = req_fire_i && req_op_load_i;
        // fill == tail is ambiguous only when full: then head == fill and its have flag decides.
        unfilled  = (fill_q != tail_q) || (count_q == CNT_W'(DEPTH) && !entry_q[fill_q].have);
        fill_en   = rsp_valid_i && unfilled;
        slot_free = !wb_valid_q || wb_ready_i;

        avail_head  = entry_q[head_q].have || (fill_en && fill_q == head_q);
        avail_head1 = entry_q[head1].have || (fill_en && fill_q == head1);
        word_head   = entry_q[head_q].have ? entry_q[head_q].data : rsp_rdata_i;
        word_head1  = entry_q[head1].have ? entry_q[head1].data : rsp_rdata_i;
        head_is_dl  = entry_q[head_q].typ == LD_DL;

        pop_single = (count_q != '0) && !head_is_dl && avail_head && slot_free;
        pop_pair   = (count_q >= CNT_W'(2)) && head_is_dl && avail_head && avail_head1 && slot_free;
        pop_n      = pop_pair ? 2'd2 : (pop_single ? 2'd1 : 2'd0);

        entry_d = entry_q;
        if (push) begin
            entry_d[tail_q].typ       = ld_encode({req_op_lb_i, req_op_lh_i, req_op_lw_i, req_op_lbu_i,
                                                   req_op_lhu_i, req_op_ldl_i, req_op_ldh_i});
            entry_d[tail_q].addr_lo   = req_addr_lo_i;
            entry_d[tail_q].commit_id = req_commit_id_i;
            entry_d[tail_q].reg_waddr = req_reg_waddr_i;
            entry_d[tail_q].data      = '0;
            entry_d[tail_q].have      = 1'b0;
        end
        if (fill_en) begin
            entry_d[fill_q].data = rsp_rdata_i;
            entry_d[fill_q].have = 1'b1;
        end
        if (pop_single || pop_pair) entry_d[head_q].have = 1'b0;
        if (pop_pair)               entry_d[head1].have  = 1'b0;

        tail_d   = tail_q + PTR_W'(push);
        fill_d   = fill_q + PTR_W'(fill_en);
        head_d   = head_q + PTR_W'(pop_n);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop_n);
        orphan_d = orphan_q || (rsp_valid_i && !unfilled);

        wb_valid_d     = wb_valid_q && !wb_ready_i;
        wb_data_d      = wb_data_q;
        wb_is64_d      = wb_is64_q;
        wb_commit_id_d = wb_commit_id_q;
        wb_reg_waddr_d = wb_reg_waddr_q;
        if (pop_single || pop_pair) begin
            wb_valid_d     = 1'b1;
            wb_is64_d      = pop_pair;
            wb_data_d      = pop_pair ? {word_head1, word_head}
                                      : {32'h0, entry_q[head_q].have ? ext_mem : ext_byp};
            wb_commit_id_d = entry_q[head_q].commit_id;
            wb_reg_waddr_d = entry_q[head_q].reg_waddr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            head_q         <= '0;
            fill_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_is64_q      <= 1'b0;
            wb_commit_id_q <= '0;
            wb_reg_waddr_q <= '0;
            orphan_q       <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
            head_q         <= head_d;
            fill_q         <= fill_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_is64_q      <= wb_is64_d;
            wb_commit_id_q <= wb_commit_id_d;
            wb_reg_waddr_q <= wb_reg_waddr_d;
            orphan_q       <= orphan_d;
        end
    end

    assign full_o         = count_q == CNT_W'(DEPTH);
    assign wb_valid_o     = wb_valid_q;
    assign wb_data_o      = wb_data_q;
    assign wb_is64_o      = wb_is64_q;
    assign wb_commit_id_o = wb_commit_id_q;
    assign wb_reg_waddr_o = wb_reg_waddr_q;
    assign rsp_orphan_o   = orphan_q;

endmodule

// File: doc/lsu_resp.md
# lsu_resp

Load-response unit on the return side of the load/store path. It records every load request the address-generation stage issues to data memory, and captures in-order 32-bit read responses. It sign- or zero-extends byte/half loads, merges the low/high halves of split 64-bit FP loads into one result, and presents one writeback per instruction, tagged with commit ID and destination register.

## Interface
Parameters:
- `DEPTH`, default 4: outstanding load entries (power of two, ≥2).

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset; synchronous, active-low. One clock domain.
- `req_fire_i`  in  1: a memory request is accepted this cycle.
- `req_op_load_i`  in  1: the request is a load. Only loads are enqueued; stores are ignored.
- `req_op_lb_i`, `req_op_lh_i`, `req_op_lw_i`, `req_op_lbu_i`, `req_op_lhu_i`, `req_op_ldl_i`, `req_op_ldh_i`  in  1 each: one-hot load type.
- `req_addr_lo_i`  in  2: address bits [1:0].
- `req_commit_id_i`  in  `COMMIT_ID_WIDTH`: commit tag.
- `req_reg_waddr_i`  in  `REG_ADDR_WIDTH`: destination register.
- `rsp_valid_i`  in  1: read data valid. Responses arrive in request order, at least 1 cycle after the request fires.
- `rsp_rdata_i`  in  32: read word.
- `full_o`  out  1: count == DEPTH. The upstream stage must stall; `req_fire_i` of a load while full is illegal.
- `wb_valid_o`  out  1: writeback valid (registered).
- `wb_ready_i`  in  1: writeback accepted.
- `wb_data_o`  out  64: result. Upper 32 bits are zero for non-64-bit loads.
- `wb_is64_o`  out  1: result is a merged ldl/ldh pair.
- `wb_commit_id_o`  out  `COMMIT_ID_WIDTH`: commit tag.
- `wb_reg_waddr_o`  out  `REG_ADDR_WIDTH`: destination register.
- `rsp_orphan_o`  out  1: sticky error; a response arrived with no unfilled entry. Cleared only by reset.

## Operation
- The queue is circular with `head` (pop), `fill` (next entry awaiting data), `tail` (push) and `count`. Each entry holds type flags, addr_lo, commit ID, waddr, data[31:0] and `have`.
- Push: on `req_fire_i && req_op_load_i`, write the entry at `tail` with `have`=0.
- Fill: on `rsp_valid_i`, write data into the entry at `fill`, set `have`, and advance `fill`. If `fill == tail` and count covers no unfilled entry, drop the data and set `rsp_orphan_o`.
- An entry is *available* this cycle if `have`=1, or if it is being filled this cycle (combinational bypass of `rsp_rdata_i`).
- The output slot is free when `!wb_valid_o || wb_ready_i`.
- Pop single: head is not ldl, head is available, slot free. Load the output register and advance head by 1.
- Pop pair: head is ldl, head+1 exists and is available, head is available, slot free. Set `wb_data_o` = {hi word, lo word}, `wb_is64_o`=1, take tag/waddr from the head entry, and advance head by 2. An ldl at head never pops alone.
- Extraction by addr_lo:
  - lb: sign-extend byte [8·a+7:8·a].
  - lbu: zero-extend the same byte.
  - lh: sign-extend half [16·a1+15:16·a1].
  - lhu: zero-extend the same half.
  - lw: the whole word.
  - An entry whose type flags are all zero behaves as lw.
- Simultaneous push, fill and pop in one cycle are all legal. `count` changes by push − pop (pop is 0, 1 or 2).
- Pointers wrap modulo DEPTH. Pair members may straddle the wrap point.
- Reset:
  - `head`, `fill`, `tail` and `count` go to 0 and every `have` flag is cleared.
  - Outputs: `wb_valid_o`=0, `wb_data_o`=0, `wb_is64_o`=0, `wb_commit_id_o`=0, `wb_reg_waddr_o`=0, `full_o`=0, `rsp_orphan_o`=0.
  - Reset mid-operation discards all entries. Responses to pre-reset requests are the system's responsibility.

## Timing
- Latency: a response in cycle N that completes the head instruction gives `wb_valid_o`=1 in N+1, provided the slot is free.
- Throughput: 1 writeback/cycle, whether single or pair.
- `wb_*` outputs are held stable while `wb_valid_o && !wb_ready_i`.
- `full_o` is combinational from `count`. It does not anticipate a same-cycle pop.
- No combinational path from `wb_ready_i` to `wb_*`; it affects only pop enables.

## Structure
- Entry struct `lsu_resp_entry_t` and load-type encoding go in the shared core package, next to the request-side types.
- One sub-module, `load_extend`: a combinational byte/half select plus sign/zero extension from (type, addr_lo, word). It is reused by the bypass path and the stored path.

## Test plan
- lb at addr_lo=3, rsp 0x80FF_0000 → wb_data_o=0x0000_0000_FFFF_FF80, wb_valid_o one cycle after rsp.
- lhu at addr_lo=2, rsp 0xBEEF_1234 → wb_data_o=0x0000_BEEF. Then lh with the same rsp → 0xFFFF_BEEF.
- Pair ldl/ldh with rsp 0x1111_2222 then 0x3333_4444 one cycle apart → single wb with wb_data_o=0x3333_4444_1111_2222, wb_is64_o=1, and the ldl commit ID.
- DEPTH=4: issue 4 loads with no rsp → full_o=1. With wb_ready_i=0, deliver 4 rsps → wb_valid_o holds the first result. Raise wb_ready_i → 4 writebacks on consecutive cycles, in order. count returns to 0.
- Wrap: pre-advance pointers to 3 and issue ldl/ldh across index 3→0 → merged result correct.
- rsp_valid_i with an empty queue → rsp_orphan_o=1 and no wb. Then assert rst_n=0 for one cycle → all outputs 0.
